// File: rtl/gray_pkg.sv
package gray_pkg;

  localparam int MAX_W = 6;
  localparam int MAX_T = 63;

  function automatic int T_OF(input int w);
    return (2 ** w) - 1;
  endfunction

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic therm_is_valid(input logic [MAX_T-1:0] t);
    logic [MAX_T:0] x;
    x = {1'b0, t};
    return ((x & (x + {{MAX_T{1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/therm_to_bin.sv
module therm_to_bin
  import gray_pkg::*;
#(
  parameter int W = 3,
  parameter int T = T_OF(W)
) (
  input  logic [T-1:0] therm,
  output logic [W-1:0] bin,
  output logic         err
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < T; i++) begin
      bin = bin + W'(therm[i]);
    end
    err = !therm_is_valid(MAX_T'(therm));
  end

endmodule

// File: rtl/gray_encoder_pipe.sv
module gray_encoder_pipe
  import gray_pkg::*;
#(
  parameter int W   = 3,
  parameter int T   = T_OF(W),
  parameter int ECW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   bin_in,
  input  logic [T-1:0]   therm_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   gray_out,
  output logic           bubble_err,
  output logic [ECW-1:0] err_count
);

  function automatic logic [ECW-1:0] sat_inc(input logic [ECW-1:0] c);
    return (&c) ? c : c + ECW'(1);
  endfunction

  logic           vld_p1;
  logic [W-1:0]   bin_p1;
  logic           err_p1;
  logic           vld_p2;
  logic [W-1:0]   gray_p2;
  logic           berr_p2;
  logic [ECW-1:0] err_cnt_p2;

  logic           s2_load;
  logic           in_fire;
  logic           out_fire;
  logic [W-1:0]   therm_bin;
  logic           therm_err;
  logic [W-1:0]   bin_s1;
  logic           err_s1;

  therm_to_bin #(
    .W (W),
    .T (T)
  ) u_therm_to_bin (
    .therm (therm_in),
    .bin   (therm_bin),
    .err   (therm_err)
  );

  always_comb begin
    s2_load  = vld_p1 && (!vld_p2 || out_ready);
    in_ready = !vld_p1 || s2_load;
    in_fire  = in_valid && in_ready;
    out_fire = vld_p2 && out_ready;
    bin_s1   = '0;
    err_s1   = 1'b0;
    if (en) begin
      if (mode) begin
        bin_s1 = therm_bin;
        err_s1 = therm_err;
      end else begin
        bin_s1 = bin_in;
      end
    end
  end

  // ---- stage 1: capture input word as binary value plus bubble flag ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1 <= 1'b1;
    end else if (s2_load) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      bin_p1 <= bin_s1;
      err_p1 <= err_s1;
    end
  end

  // ---- stage 2: Gray conversion, output register and error counter ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      gray_p2 <= '0;
      berr_p2 <= 1'b0;
    end else if (s2_load) begin
      vld_p2  <= 1'b1;
      gray_p2 <= W'(bin2gray(MAX_W'(bin_p1)));
      berr_p2 <= err_p1;
    end else if (out_fire) begin
      vld_p2  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_p2 <= '0;
    end else if (out_fire && berr_p2) begin
      err_cnt_p2 <= sat_inc(err_cnt_p2);
    end
  end

  assign out_valid  = vld_p2;
  assign gray_out   = gray_p2;
  assign bubble_err = berr_p2;
  assign err_count  = err_cnt_p2;

endmodule

// File: tb/tb_gray_encoder_pipe.sv
module tb_gray_encoder_pipe;

  localparam int W   = 3;
  localparam int T   = 7;
  localparam int ECW = 2;
  localparam int CNT_MAX = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           mode;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   bin_in;
  logic [T-1:0]   therm_in;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   gray_out;
  logic           bubble_err;
  logic [ECW-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_total = 0;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         acc_cyc[$];
  int         got_cyc[$];

  always #5 clk = ~clk;

  gray_encoder_pipe #(
    .W   (W),
    .ECW (ECW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .bin_in     (bin_in),
    .therm_in   (therm_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gray_out   (gray_out),
    .bubble_err (bubble_err),
    .err_count  (err_count)
  );

  // reference: {bubble, gray} for one accepted word
  function automatic logic [3:0] ref_word(input logic e, input logic m,
                                          input logic [2:0] b, input logic [6:0] t);
    int ones;
    int v;
    logic bad;
    ones = 0;
    v    = 0;
    bad  = 1'b0;
    if (e) begin
      if (m) begin
        for (int i = 0; i < 7; i++) if (t[i]) ones++;
        v   = ones;
        bad = (int'(t) != (1 << ones) - 1);
      end else begin
        v = int'(b);
      end
    end
    return {bad, 3'(v ^ (v >> 1))};
  endfunction

  function automatic logic [6:0] rand_bubbled();
    logic [6:0] t;
    int ones;
    do begin
      t = 7'($urandom_range(0, 127));
      ones = 0;
      for (int i = 0; i < 7; i++) if (t[i]) ones++;
    end while (int'(t) == (1 << ones) - 1);
    return t;
  endfunction

  task automatic step();
    #3;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_word(en, mode, bin_in, therm_in));
      acc_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      got_q.push_back({bubble_err, gray_out});
      got_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    got_cyc.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (got_q.size() < exp_q.size() && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drain: got %0d words, expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bin_in = '0; therm_in = '0;
    repeat (2) step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL reset_err_count: got %0d, expected 0", err_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    checks++;
    if (gray_out !== '0 || bubble_err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got gray=%b err=%b, expected 000/0", gray_out, bubble_err);
    end
    repeat (3) step();
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL reset_idle: got %0d transfers, expected 0", got_q.size()); end
    clear_q();
    err_total = 0;
  endtask

  task automatic test_bin_sweep();
    logic [2:0] tab [8];
    int exp_cnt;
    tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    clear_q();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      in_valid = 1'b1;
      bin_in   = 3'(v);
      step();
    end
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i][3]) err_total++;
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sweep_model[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
      checks++;
      if (got_q[i][2:0] !== tab[i]) begin
        errors++; $display("FAIL sweep_table[%0d]: got %b, expected %b", i, got_q[i][2:0], tab[i]);
      end
      checks++;
      if (got_cyc[i] != acc_cyc[0] + 2 + i) begin
        errors++; $display("FAIL sweep_timing[%0d]: got cycle %0d, expected %0d", i, got_cyc[i], acc_cyc[0] + 2 + i);
      end
    end
    exp_cnt = (err_total > CNT_MAX) ? CNT_MAX : err_total;
    checks++;
    if (err_count !== ECW'(exp_cnt)) begin errors++; $display("FAIL sweep_err_count: got %0d, expected %0d", err_count, exp_cnt); end
  endtask

  task automatic test_therm();
    logic [6:0] words [4];
    logic [2:0] tab [4];
    int exp_cnt;
    words = '{7'b0000000, 7'b0011111, 7'b1111111, 7'b0101111};
    tab   = '{3'b000, 3'b111, 3'b100, 3'b111};
    clear_q();
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      therm_in = words[i];
      step();
    end
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i][3]) err_total++;
      checks++;
      if (got_q[i] !== exp_q[i] || got_q[i] !== {(i == 3), tab[i]}) begin
        errors++; $display("FAIL therm[%0d]: got %b, expected %b", i, got_q[i], {(i == 3), tab[i]});
      end
    end
    exp_cnt = (err_total > CNT_MAX) ? CNT_MAX : err_total;
    checks++;
    if (err_count !== ECW'(exp_cnt)) begin errors++; $display("FAIL therm_err_count: got %0d, expected %0d", err_count, exp_cnt); end
  endtask

  task automatic test_enable();
    int exp_cnt;
    clear_q();
    out_ready = 1'b1;
    in_valid = 1'b1; en = 1'b0; mode = 1'b0; bin_in = 3'd5; step();
    en = 1'b0; mode = 1'b1; therm_in = 7'b0101111; step();
    en = 1'b1; mode = 1'b0; bin_in = 3'd5; step();
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i][3]) err_total++;
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL enable[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
    exp_cnt = (err_total > CNT_MAX) ? CNT_MAX : err_total;
    checks++;
    if (err_count !== ECW'(exp_cnt)) begin errors++; $display("FAIL enable_err_count: got %0d, expected %0d", err_count, exp_cnt); end
  endtask

  task automatic test_backpressure();
    logic [2:0] words [5];
    logic [2:0] held;
    int n;
    int exp_cnt;
    for (int i = 0; i < 5; i++) words[i] = 3'($urandom_range(0, 7));
    clear_q();
    mode = 1'b0; en = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; bin_in = words[0];
    n = 0;
    while (got_q.size() == 0 && n < 20) begin
      step();
      n++;
      if (exp_q.size() < 5) bin_in = words[exp_q.size()]; else in_valid = 1'b0;
    end
    out_ready = 1'b0;
    held = gray_out;
    repeat (4) begin
      step();
      if (exp_q.size() < 5) bin_in = words[exp_q.size()]; else in_valid = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b1 || gray_out !== held) begin
      errors++; $display("FAIL bp_hold: got valid=%b gray=%b, expected 1/%b", out_valid, gray_out, held);
    end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL bp_no_transfer: got %0d words, expected 1", got_q.size()); end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() < 5 && n < 20) begin
      step();
      n++;
      if (exp_q.size() < 5) bin_in = words[exp_q.size()]; else in_valid = 1'b0;
    end
    drain();
    checks++;
    if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d words, expected 5", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i][3]) err_total++;
      checks++;
      if (got_q[i] !== ref_word(1'b1, 1'b0, words[i], 7'd0)) begin
        errors++; $display("FAIL bp_word[%0d]: got %b, expected %b", i, got_q[i], ref_word(1'b1, 1'b0, words[i], 7'd0));
      end
    end
    exp_cnt = (err_total > CNT_MAX) ? CNT_MAX : err_total;
    checks++;
    if (err_count !== ECW'(exp_cnt)) begin errors++; $display("FAIL bp_err_count: got %0d, expected %0d", err_count, exp_cnt); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    clear_q();
    mode = 1'b1; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      therm_in = rand_bubbled();
      step();
    end
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i][3]) err_total++;
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL sat_word[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
    exp_cnt = (err_total > CNT_MAX) ? CNT_MAX : err_total;
    checks++;
    if (err_count !== ECW'(exp_cnt)) begin errors++; $display("FAIL sat_err_count: got %0d, expected %0d", err_count, exp_cnt); end
  endtask

  task automatic test_mid_reset();
    clear_q();
    out_ready = 1'b0; mode = 1'b1; en = 1'b1;
    in_valid = 1'b1; therm_in = rand_bubbled(); step();
    therm_in = rand_bubbled(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_out_valid: got %b, expected 0", out_valid); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL mrst_err_count: got %0d, expected 0", err_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_in_ready: got %b, expected 1", in_ready); end
    out_ready = 1'b1;
    repeat (4) step();
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL mrst_discard: got %0d words, expected 0", got_q.size()); end
    clear_q();
    err_total = 0;
  endtask

  task automatic test_random();
    int exp_cnt;
    clear_q();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 7);
      en        = ($urandom_range(0, 9) < 9);
      mode      = 1'($urandom_range(0, 1));
      bin_in    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) therm_in = 7'((1 << $urandom_range(0, 7)) - 1);
      else                           therm_in = 7'($urandom_range(0, 127));
      step();
    end
    drain();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (exp_q[i][3]) err_total++;
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_word[%0d]: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
    exp_cnt = (err_total > CNT_MAX) ? CNT_MAX : err_total;
    checks++;
    if (err_count !== ECW'(exp_cnt)) begin errors++; $display("FAIL rand_err_count: got %0d, expected %0d", err_count, exp_cnt); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bin_in = '0; therm_in = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_bin_sweep();
    test_therm();
    test_enable();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
